decoder_arbiter: RTL

//  Shares one registered 3-to-8 active-low one-hot decoder between NREQ requesters.

---
 rtl/decoder_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/decoder_arbiter.sv
// decoder_arbiter: round-robin arbiter sharing one registered 3-to-8 active-low
// one-hot decoder between NREQ requesters, with valid/ready on both sides.
module decoder_arbiter #(
  parameter int NREQ  = 4,
  parameter int SEL_W = 3,
  parameter int OUT_W = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*SEL_W-1:0] req_sel,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      grant_cnt
);

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    EMPTY = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic             found;
  logic             can_accept;
  logic             accept;
  logic [SEL_W-1:0] sel_w;
  logic [OUT_W-1:0] decoded;

  // Round-robin search: first pending requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant strobe and the winner's select; output slot must be free or draining.
  always_comb begin
    can_accept = (state != WARM) && (!out_valid || out_ready);
    accept     = found && can_accept;
    req_ready  = '0;
    sel_w      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_w        = req_sel[i*SEL_W +: SEL_W];
      end
    end
    decoded = ~(OUT_W'(1) << sel_w);
    busy    = out_valid | (|req_valid);
  end

  // Sequencer: warm-up after reset, then load on accept, hold on stall, clear on drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= WARM;
      out_valid <= 1'b0;
      out_data  <= {OUT_W{1'b1}};
      out_id    <= '0;
      ptr       <= '0;
      grant_cnt <= '0;
    end else begin
      case (state)
        WARM: state <= EMPTY;
        default: begin
          if (accept) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= decoded;
            out_id    <= win;
            if (win == ID_W'(NREQ - 1)) ptr <= '0;
            else                        ptr <= win + ID_W'(1);
            if (grant_cnt != {CNT_W{1'b1}}) grant_cnt <= grant_cnt + CNT_W'(1);
          end else if (out_valid && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= {OUT_W{1'b1}};
          end
        end
      endcase
    end
  end

endmodule
